// File: rtl/systolic_skew_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_if
//
// Bundles the buffer-load port, the start control and the array-facing
// outputs of systolic_skew_feeder.
//
//   wr_en / wr_sel / wr_row / wr_col / wr_data : element write into the A
//                                                (wr_sel=0) or B (wr_sel=1)
//                                                block buffer
//   start                                      : level-sampled pass request
//   west_data                                  : N lanes to the array rows
//   north_data                                 : N lanes to the array columns
//   arr_clr / busy / done                      : array clear, activity, and
//                                                pass-complete pulse
//
// master : the side that loads blocks and requests passes
// slave  : the feeder itself
// -----------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 4
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic                   wr_en;
    logic                   wr_sel;
    logic [RW-1:0]          wr_row;
    logic [RW-1:0]          wr_col;
    logic [BIT_WIDTH-1:0]   wr_data;
    logic                   start;
    logic [N*BIT_WIDTH-1:0] west_data;
    logic [N*BIT_WIDTH-1:0] north_data;
    logic                   arr_clr;
    logic                   busy;
    logic                   done;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  west_data, north_data, arr_clr, busy, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output west_data, north_data, arr_clr, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Input-side feeder for an N x N systolic multiply array. Holds one A block
// and one B block and, for each requested pass, drives the array edges:
//   CLEAR  (1 cycle)            : arr_clr high, all lanes zero
//   STREAM (2N-1 cycles, t)     : west lane i = A[i][t-i], north lane j =
//                                 B[t-j][j], zero outside the diagonal band
//   FLUSH  (FLUSH_CYCLES cycles): all lanes zero while the array drains
//   DONE   (1 cycle)            : done pulse, then back to IDLE
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (state, counter and all outputs)
//   bus  : systolic_skew_feeder_if.slave
//            wr_en/wr_sel/wr_row/wr_col/wr_data : buffer writes (IDLE only)
//            start                              : pass request (IDLE only)
//            west_data/north_data               : skewed lanes to the array
//            arr_clr/busy/done                  : array control and status
//
// Elements are carried bit-exact; no arithmetic touches the data path.
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
    parameter int BIT_WIDTH    = 16,
    parameter int N            = 4,
    parameter int FLUSH_CYCLES = N + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    systolic_skew_feeder_if.slave   bus
);

    localparam int RW        = (N > 1) ? $clog2(N) : 1;
    localparam int STREAM_LEN = 2 * N - 1;
    localparam int MAX_CNT   = (STREAM_LEN > FLUSH_CYCLES) ? STREAM_LEN : FLUSH_CYCLES;
    localparam int CW        = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Block buffers are deliberately not reset: a reset only aborts a pass.
    logic [BIT_WIDTH-1:0] buf_a [N][N];
    logic [BIT_WIDTH-1:0] buf_b [N][N];

    logic [N*BIT_WIDTH-1:0] west_lanes;
    logic [N*BIT_WIDTH-1:0] north_lanes;

    logic [N*BIT_WIDTH-1:0] west_q,  west_d;
    logic [N*BIT_WIDTH-1:0] north_q, north_d;
    logic                   arr_clr_q, arr_clr_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;

    // -------------------------------------------------------------------------
    // Buffer load. Writes are accepted only while idle and out of reset, so
    // contents stay frozen for the whole pass. A write in the same cycle that
    // start is sampled still lands; the CLEAR cycle gives it time to be read
    // back at STREAM t=0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && bus.wr_en) begin
            if (bus.wr_sel) begin
                buf_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end else begin
                buf_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer: next state. The counter restarts at zero on every state
    // entry and indexes t while streaming.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                cnt_d   = '0;
            end
            S_STREAM: begin
                if (cnt_q == CW'(STREAM_LEN - 1)) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // start is not looked at here, which guarantees one IDLE
                // cycle between back-to-back passes.
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Diagonal skew. Lane k reads the buffer at offset (t - k); the lane is
    // zero when that offset falls outside 0..N-1. Lookups use the next-cycle
    // counter so the registered outputs line up with the state they belong to.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [CW-1:0] off;
        logic          hit;

        assign off = cnt_d - CW'(k);

        if (k == 0) begin : g_first
            assign hit = (cnt_d < CW'(N));
        end else begin : g_rest
            assign hit = (cnt_d >= CW'(k)) && (cnt_d < CW'(k + N));
        end

        assign west_lanes[k*BIT_WIDTH +: BIT_WIDTH]  = hit ? buf_a[k][off[RW-1:0]] : '0;
        assign north_lanes[k*BIT_WIDTH +: BIT_WIDTH] = hit ? buf_b[off[RW-1:0]][k] : '0;
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so every output is a plain register
    // that is valid in the same cycle as the state it describes.
    // -------------------------------------------------------------------------
    always_comb begin
        west_d    = '0;
        north_d   = '0;
        arr_clr_d = 1'b0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        if (state_d == S_STREAM) begin
            west_d  = west_lanes;
            north_d = north_lanes;
        end
        if (state_d == S_CLEAR) begin
            arr_clr_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            west_q    <= '0;
            north_q   <= '0;
            arr_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            west_q    <= west_d;
            north_q   <= north_d;
            arr_clr_q <= arr_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.west_data  = west_q;
    assign bus.north_data = north_q;
    assign bus.arr_clr    = arr_clr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
